// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and multi-cycle multiply stalls, branch flush,
// and EX operand forwarding selects computed in ID and registered into EX.
module hazard_ctrl #(
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_is_mul,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              imm_sel_ex,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StRun       = 2'b00,
    StLoadStall = 2'b01,
    StMulBusy   = 2'b10
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);

  state_e     r_state;
  logic [3:0] r_cnt;
  // Index 0 = EX, 1 = MEM, 2 = WB.
  shadow_t    r_pipe [3];
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic       r_imm;

  logic       w_rt_read;
  logic       w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic       w_load_use;
  logic       w_busy;
  logic       w_advance;
  logic [1:0] w_fwd_a, w_fwd_b;
  shadow_t    w_new;

  function automatic logic hit(shadow_t e, logic [REG_AW-1:0] r);
    return e.valid & e.reg_write & (e.rd != '0) & (e.rd == r);
  endfunction

  always_comb begin
    // An immediate replaces rt on operand B, so rt is not a real read.
    w_rt_read  = id_use_rt & ~id_imm;
    w_ex_a     = id_use_rs & hit(r_pipe[0], id_rs);
    w_ex_b     = w_rt_read & hit(r_pipe[0], id_rt);
    w_mem_a    = id_use_rs & hit(r_pipe[1], id_rs);
    w_mem_b    = w_rt_read & hit(r_pipe[1], id_rt);
    w_load_use = id_valid & r_pipe[0].mem_read & (w_ex_a | w_ex_b);
    w_busy     = (r_state == StMulBusy);
    stall      = w_busy | (w_load_use & ~ex_branch_taken);
    bubble_ex  = w_busy | w_load_use | ex_branch_taken;
    flush_id   = ex_branch_taken;
    w_advance  = id_valid & ~stall & ~bubble_ex;
    w_fwd_a    = w_ex_a ? 2'b01 : (w_mem_a ? 2'b10 : 2'b00);
    w_fwd_b    = w_ex_b ? 2'b01 : (w_mem_b ? 2'b10 : 2'b00);
    w_new      = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_cnt   <= 4'd0;
      for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
      r_imm   <= 1'b0;
    end else begin
      r_pipe[0] <= w_advance ? w_new : '0;
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];
      r_fwd_a   <= w_advance ? w_fwd_a : 2'b00;
      r_fwd_b   <= w_advance ? w_fwd_b : 2'b00;
      r_imm     <= w_advance ? id_imm : 1'b0;
      case (r_state)
        StMulBusy: begin
          // A branch here only flushes; the countdown continues untouched.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt < 4'd2) r_state <= StRun;
        end
        default: begin
          if (w_advance && id_is_mul) begin
            r_state <= StMulBusy;
            r_cnt   <= MulCnt;
          end else if (w_load_use && !ex_branch_taken) begin
            r_state <= StLoadStall;
          end else begin
            r_state <= StRun;
          end
        end
      endcase
    end
  end

  assign fwd_a_sel  = r_fwd_a;
  assign fwd_b_sel  = r_fwd_b;
  assign imm_sel_ex = r_imm;
  assign state      = r_state;

endmodule
